// File: rtl/fetch_pc_gen_pkg.sv
// Shared fetch-stage definitions.
// Holds the reset vector, the stall and bus widths, and the Stop/NoStop
// levels of a stall bit. Every fetch-stage file imports this package so that
// all of them agree on these constants.
package fetch_pc_gen_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

  localparam int STALL_W     = 6;
  localparam int BR_WD       = 33;
  localparam int IF_TO_ID_WD = 66;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

endpackage

// File: rtl/fetch_pc_gen.sv
// Program-counter generator for the instruction fetch stage.
// It issues one 8-byte-aligned fetch per cycle to the instruction SRAM. The
// fetched data comes back one cycle later as 64 bits.
//
// Ports
//   clk, rst        rising-edge clock; synchronous active-high reset
//   flush, new_pc   exception/eret redirect. This has the highest priority.
//   stall           pipeline stall vector. stall[0] holds the PC.
//   br_bus          {taken, target[31:0]}, the taken-branch redirect from ID
//   inst_sram_en    fetch request enable
//   inst_sram_wen   byte write enables. These are always 0.
//   inst_sram_addr  8-byte-aligned fetch address
//   if_to_id_bus    {discard, ce, pc_idef, id_pc} sent to the decode stage
module fetch_pc_gen
  import fetch_pc_gen_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [31:0]            new_pc,
  input  logic [STALL_W-1:0]     stall,
  input  logic [BR_WD-1:0]       br_bus,
  output logic                   inst_sram_en,
  output logic [7:0]             inst_sram_wen,
  output logic [31:0]            inst_sram_addr,
  output logic [IF_TO_ID_WD-1:0] if_to_id_bus
);

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic        r_ce;
  logic [31:0] r_pc;
  logic        r_pend_v;
  logic        r_pend_fl;
  logic [31:0] r_pend_pc;
  logic        r_discard;

  logic        w_adv;
  logic        w_br_take;
  logic [31:0] w_br_tgt;
  logic [31:0] w_pc_aln;
  logic [31:0] w_pc_seq;
  logic [31:0] w_pc_nxt;
  logic        w_unused_stall;

  assign w_br_take = br_bus[BR_WD-1];
  assign w_br_tgt  = br_bus[31:0];
  assign w_pc_aln  = {r_pc[31:3], 3'b000};
  assign w_pc_seq  = w_pc_aln + 32'd8;

  // Only stall[0] affects the PC. The remaining bits belong to later stages.
  assign w_unused_stall = ^stall[STALL_W-1:1];

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_BOOT;
    else     r_state <= w_state_nxt;
  end

  // ---- next-state logic ----
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_BOOT:  w_state_nxt = S_RUN;
      S_RUN:   if (stall[0] == STOP)    w_state_nxt = S_HOLD;
      S_HOLD:  if (stall[0] == NO_STOP) w_state_nxt = S_RUN;
      default: w_state_nxt = S_BOOT;
    endcase
  end

  // ---- output logic: the PC advances whenever not booting and not stalled ----
  always_comb begin
    w_adv = (r_state != S_BOOT) && (stall[0] == NO_STOP);
  end

  // Redirect priority: flush, then branch, then a captured pending target,
  // then the sequential fetch.
  always_comb begin
    w_pc_nxt = w_pc_seq;
    if (flush)          w_pc_nxt = new_pc;
    else if (w_br_take) w_pc_nxt = w_br_tgt;
    else if (r_pend_v)  w_pc_nxt = r_pend_pc;
  end

  // ---- PC / pending-redirect registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ce      <= 1'b0;
      r_pc      <= RESET_VECTOR;
      r_pend_v  <= 1'b0;
      r_pend_fl <= 1'b0;
      r_pend_pc <= 32'd0;
      r_discard <= 1'b0;
    end else begin
      r_ce <= 1'b1;
      if (w_adv) begin
        r_pc      <= w_pc_nxt;
        r_pend_v  <= 1'b0;
        r_pend_fl <= 1'b0;
      end else if (flush) begin
        // A flush target always replaces any pending branch.
        r_pend_pc <= new_pc;
        r_pend_v  <= 1'b1;
        r_pend_fl <= 1'b1;
      end else if (w_br_take && !(r_pend_v && r_pend_fl)) begin
        // A branch never replaces a pending flush target.
        r_pend_pc <= w_br_tgt;
        r_pend_v  <= 1'b1;
        r_pend_fl <= 1'b0;
      end
      // The fetch issued during a taken-branch cycle is on the wrong path.
      r_discard <= w_adv & w_br_take & ~flush;
    end
  end

  assign inst_sram_en   = r_ce & (stall[0] == NO_STOP);
  assign inst_sram_wen  = 8'h00;
  assign inst_sram_addr = w_pc_aln;
  // When pc_idef differs from id_pc (pc[2] set), decode drops slot 0.
  assign if_to_id_bus   = {r_discard, r_ce, r_pc, w_pc_aln};

endmodule

// File: tb/tb_fetch_pc_gen.sv
module tb_fetch_pc_gen;
  import fetch_pc_gen_pkg::*;

  logic                   clk;
  logic                   rst;
  logic                   flush;
  logic [31:0]            new_pc;
  logic [STALL_W-1:0]     stall;
  logic [BR_WD-1:0]       br_bus;
  logic                   inst_sram_en;
  logic [7:0]             inst_sram_wen;
  logic [31:0]            inst_sram_addr;
  logic [IF_TO_ID_WD-1:0] if_to_id_bus;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_pc_gen dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .new_pc         (new_pc),
    .stall          (stall),
    .br_bus         (br_bus),
    .inst_sram_en   (inst_sram_en),
    .inst_sram_wen  (inst_sram_wen),
    .inst_sram_addr (inst_sram_addr),
    .if_to_id_bus   (if_to_id_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; new_pc = 32'd0; stall = '0; br_bus = '0;
    tick(); tick();
    chk("rst_en",      inst_sram_en, 0);
    chk("rst_ce",      if_to_id_bus[64], 0);
    chk("rst_discard", if_to_id_bus[65], 0);
    chk("rst_addr",    inst_sram_addr, 32'hBFC00000);
    chk("rst_wen",     inst_sram_wen, 0);

    // Boot sequence
    rst = 1'b0;
    chk("c1_ce",   if_to_id_bus[64], 0);
    chk("c1_addr", inst_sram_addr, 32'hBFC00000);
    tick();
    chk("c2_en",   inst_sram_en, 1);
    chk("c2_addr", inst_sram_addr, 32'hBFC00000);
    tick();
    chk("c3_addr", inst_sram_addr, 32'hBFC00008);
    tick();
    chk("c4_addr", inst_sram_addr, 32'hBFC00010);

    // Taken branch with no stall
    br_bus = {1'b1, 32'hBFC00104};
    tick();
    br_bus = '0;
    chk("br_addr",    inst_sram_addr, 32'hBFC00100);
    chk("br_pcidef",  if_to_id_bus[63:32], 32'hBFC00104);
    chk("br_idpc",    if_to_id_bus[31:0], 32'hBFC00100);
    chk("br_discard", if_to_id_bus[65], 1);
    tick();
    chk("br_seq_addr",    inst_sram_addr, 32'hBFC00108);
    chk("br_discard_clr", if_to_id_bus[65], 0);

    // Branch captured during a 3-cycle stall
    stall = 6'b000001; br_bus = {1'b1, 32'h80000020};
    #1;
    chk("stall_en", inst_sram_en, 0);
    tick();
    br_bus = '0;
    chk("stall_hold1", inst_sram_addr, 32'hBFC00108);
    chk("stall_nodisc", if_to_id_bus[65], 0);
    tick(); tick();
    chk("stall_hold3", inst_sram_addr, 32'hBFC00108);
    stall = '0;
    tick();
    chk("pend_apply", if_to_id_bus[63:32], 32'h80000020);
    tick();
    chk("pend_clear", inst_sram_addr, 32'h80000028);

    // Stalled: flush first, then branch -> flush target kept
    stall = 6'b000001; flush = 1'b1; new_pc = 32'hBFC00380;
    tick();
    flush = 1'b0; br_bus = {1'b1, 32'h80001000};
    tick();
    br_bus = '0; stall = '0;
    tick();
    chk("pend_fl_keep", if_to_id_bus[63:32], 32'hBFC00380);

    // Stalled: branch first, then flush -> flush overwrites
    stall = 6'b000001; br_bus = {1'b1, 32'h80002000};
    tick();
    br_bus = '0; flush = 1'b1; new_pc = 32'hBFC00400;
    tick();
    flush = 1'b0; stall = '0;
    tick();
    chk("pend_fl_over", if_to_id_bus[63:32], 32'hBFC00400);

    // Flush and branch in the same cycle -> flush wins, no discard
    flush = 1'b1; new_pc = 32'hBFC00380; br_bus = {1'b1, 32'h80003000};
    tick();
    flush = 1'b0; br_bus = '0;
    chk("fl_br_pc",      if_to_id_bus[63:32], 32'hBFC00380);
    chk("fl_br_discard", if_to_id_bus[65], 0);

    // Address wrap, with pc[2] set so id_pc differs from pc_idef
    flush = 1'b1; new_pc = 32'hFFFFFFFC;
    tick();
    flush = 1'b0;
    chk("wrap_addr",   inst_sram_addr, 32'hFFFFFFF8);
    chk("wrap_pcidef", if_to_id_bus[63:32], 32'hFFFFFFFC);
    tick();
    chk("wrap_next",   inst_sram_addr, 32'h00000000);
    tick();
    chk("wrap_seq",    inst_sram_addr, 32'h00000008);

    // Reset while a branch is pending
    stall = 6'b000001; br_bus = {1'b1, 32'h80004000};
    tick();
    br_bus = '0; rst = 1'b1;
    tick();
    chk("rst_pend_ce", if_to_id_bus[64], 0);
    chk("rst_pend_en", inst_sram_en, 0);
    chk("rst_pend_pc", if_to_id_bus[63:32], 32'hBFC00000);
    rst = 1'b0; stall = '0;
    chk("rst_pend_boot", inst_sram_addr, 32'hBFC00000);
    tick();
    chk("rst_pend_run_en", inst_sram_en, 1);
    chk("rst_pend_run",    inst_sram_addr, 32'hBFC00000);
    tick();
    chk("rst_pend_drop",   inst_sram_addr, 32'hBFC00008);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
